// File: rtl/store_write_buffer.sv
// rtl/store_write_buffer.sv - aligning store buffer that drains stores in order over a req/ack port
module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   st_valid,
  output logic                   st_ready,
  input  logic [AW-1:0]          st_addr,
  input  logic [31:0]            st_data,
  input  logic [1:0]             st_size,
  output logic                   misalign,
  output logic                   mem_req,
  input  logic                   mem_ack,
  output logic [AW-1:0]          mem_addr,
  output logic [31:0]            mem_wdata,
  output logic [3:0]             mem_be,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Entry storage: already aligned, so the drain side is a plain read of the head.
  logic [AW-1:0] r_addr_q  [DEPTH];
  logic [31:0]   r_wdata_q [DEPTH];
  logic [3:0]    r_be_q    [DEPTH];

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_misalign;

  logic          w_legal;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [AW-1:0] w_word_addr;
  logic          w_accept;
  logic          w_push;
  logic          w_reject;
  logic          w_pop;
  logic          w_not_full;
  logic          w_has_head;

  // Occupancy flags come from registered state only, so st_ready never depends on mem_ack.
  assign w_not_full = (r_count < FULL_COUNT);
  assign w_has_head = (r_count != '0);

  // Natural alignment check: halves on even addresses, words on multiples of four.
  always_comb begin
    w_legal = 1'b0;
    case (st_size)
      SZ_BYTE: w_legal = 1'b1;
      SZ_HALF: w_legal = ~st_addr[0];
      SZ_WORD: w_legal = (st_addr[1:0] == 2'b00);
      default: w_legal = 1'b0;
    endcase
  end

  // Lane steering: replicate the data across lanes and let the byte enables pick the bytes.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = st_data;
    case (st_size)
      SZ_BYTE: begin
        w_be    = 4'b0001 << st_addr[1:0];
        w_wdata = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        w_be    = st_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{st_data[15:0]}};
      end
      SZ_WORD: begin
        w_be    = 4'b1111;
        w_wdata = st_data;
      end
      default: begin
        w_be    = 4'b0000;
        w_wdata = st_data;
      end
    endcase
  end

  assign w_word_addr = {st_addr[AW-1:2], 2'b00};

  // A request is only looked at when the buffer has room; illegal ones are dropped.
  assign w_accept = st_valid && w_not_full;
  assign w_push   = w_accept && w_legal;
  assign w_reject = w_accept && !w_legal;
  assign w_pop    = w_has_head && mem_ack;

  // Write the aligned entry into the tail slot; contents need no reset since count gates them.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr_q[r_wr_ptr]  <= w_word_addr;
      r_wdata_q[r_wr_ptr] <= w_wdata;
      r_be_q[r_wr_ptr]    <= w_be;
    end
  end

  // Tail pointer advances on every push and wraps naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
    end
  end

  // Head pointer advances when memory takes the head entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Occupancy: simultaneous push and pop cancel out; push is already blocked when full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // One-cycle rejection flag for the cycle after an illegal request was seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_reject;
    end
  end

  assign st_ready = w_not_full;
  assign misalign = r_misalign;
  assign mem_req  = w_has_head;
  assign empty    = ~w_has_head;
  assign count    = r_count;

  // Head fields are forced to zero when nothing is held so a stray write has no byte enables.
  assign mem_addr  = w_has_head ? r_addr_q[r_rd_ptr]  : '0;
  assign mem_wdata = w_has_head ? r_wdata_q[r_rd_ptr] : '0;
  assign mem_be    = w_has_head ? r_be_q[r_rd_ptr]    : '0;

endmodule

// File: tb/tb_store_write_buffer.sv
// tb/tb_store_write_buffer.sv - scoreboard bench for store_write_buffer
module tb_store_write_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic [1:0]    st_size;
  logic          misalign;
  logic          mem_req;
  logic          mem_ack;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic          empty;
  logic [2:0]    count;

  store_write_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_size   (st_size),
    .misalign  (misalign),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .empty     (empty),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } ent_t;

  ent_t sb_q[$];
  ent_t pend_ent;
  bit   pend_push;
  bit   pend_mis;
  bit   exp_mis;
  int   n_cmp;
  int   n_fail;
  int   mon_sz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int size_bytes(input logic [1:0] size);
    if (size == 2'd0) return 1;
    if (size == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit ref_legal(input logic [31:0] addr, input logic [1:0] size);
    if (size == 2'd3) return 1'b0;
    return (addr % size_bytes(size)) == 0;
  endfunction

  // Which memory bytes the store covers, and what byte of the register lands in each lane.
  function automatic ent_t ref_align(input logic [31:0] addr, input logic [31:0] data,
                                     input logic [1:0] size);
    ent_t e;
    int   nb;
    int   off;
    nb     = size_bytes(size);
    off    = int'(addr % 4);
    e.addr = addr - off;
    e.be   = 4'b0000;
    e.wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + nb) e.be[i] = 1'b1;
      e.wdata[8*i +: 8] = data[8*(i % nb) +: 8];
    end
    return e;
  endfunction

  // One clock of stimulus, starting and ending just after a rising edge.
  task automatic cycle(input bit v, input logic [31:0] addr, input logic [31:0] data,
                       input logic [1:0] size, input bit ack);
    bit room;
    st_valid = v;
    st_addr  = addr;
    st_data  = data;
    st_size  = size;
    mem_ack  = ack;
    room      = sb_q.size() < DEPTH;
    pend_push = v && room && ref_legal(addr, size);
    pend_mis  = v && room && !ref_legal(addr, size);
    pend_ent  = ref_align(addr, data, size);
    @(posedge clk);
    if (pend_push) sb_q.push_back(pend_ent);
    exp_mis = pend_mis;
    #1;
  endtask

  task automatic idle(input bit ack, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 2'd0, ack);
  endtask

  task automatic do_reset(input int n);
    st_valid  = 1'b0;
    rst       = 1'b1;
    sb_q.delete();
    pend_push = 1'b0;
    pend_mis  = 1'b0;
    exp_mis   = 1'b0;
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_mem_be", mem_be, 0);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: compare DUT state with the model mid-cycle and retire the head on a handshake.
  always @(negedge clk) begin
    mon_sz = sb_q.size();
    check("count", count, mon_sz);
    check("st_ready", st_ready, mon_sz < DEPTH);
    check("mem_req", mem_req, mon_sz != 0);
    check("empty", empty, mon_sz == 0);
    check("misalign", misalign, exp_mis);
    if (mon_sz != 0) begin
      check("mem_addr", mem_addr, sb_q[0].addr);
      check("mem_wdata", mem_wdata, sb_q[0].wdata);
      check("mem_be", mem_be, sb_q[0].be);
      if (mem_ack && !rst) void'(sb_q.pop_front());
    end else begin
      check("idle_addr", mem_addr, 0);
      check("idle_wdata", mem_wdata, 0);
      check("idle_be", mem_be, 0);
    end
  end

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    exp_mis  = 1'b0;
    rst      = 1'b1;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    st_size  = '0;
    mem_ack  = 1'b0;
    #1;
    do_reset(2);

    // Byte store to the top lane of a word.
    cycle(1'b1, 32'h0000_1003, 32'h0000_00A5, 2'd0, 1'b1);
    check("t1_req", mem_req, 1);
    check("t1_addr", mem_addr, 32'h0000_1000);
    check("t1_be", mem_be, 4'b1000);
    check("t1_wdata", mem_wdata, 32'hA5A5_A5A5);
    cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    check("t1_empty", empty, 1);

    // Upper half, then an unaligned word that must be rejected.
    cycle(1'b1, 32'h0000_2002, 32'h1234_BEEF, 2'd1, 1'b0);
    check("t2_be", mem_be, 4'b1100);
    check("t2_wdata", mem_wdata, 32'hBEEF_BEEF);
    idle(1'b1, 1);
    cycle(1'b1, 32'h0000_2001, 32'hDEAD_0001, 2'd2, 1'b1);
    check("t2_misalign", misalign, 1);
    check("t2_count", count, 0);
    idle(1'b1, 1);
    check("t2_misalign_gone", misalign, 0);

    // Fill past capacity with memory stalled, then drain in order.
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h0000_4000 + 4*i, 32'h1000_0000 + i, 2'd2, 1'b0);
    check("t3_ready", st_ready, 0);
    check("t3_count", count, 4);
    idle(1'b1, 4);
    check("t3_drained", count, 0);
    idle(1'b1, 1);

    // Push and pop on the same edge with two entries held.
    cycle(1'b1, 32'h0000_5000, 32'hAAAA_0001, 2'd2, 1'b0);
    cycle(1'b1, 32'h0000_5004, 32'hAAAA_0002, 2'd2, 1'b0);
    cycle(1'b1, 32'h0000_5009, 32'hAAAA_0003, 2'd0, 1'b1);
    check("t4_count", count, 2);
    idle(1'b1, 3);

    // Reset with three entries outstanding.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h0000_6000 + 4*i, 32'hBBBB_0000 + i, 2'd2, 1'b0);
    check("t5_count", count, 3);
    do_reset(1);

    // Stalled head must stay put while the tail keeps filling.
    cycle(1'b1, 32'h0000_3000, 32'hCAFE_F00D, 2'd2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 32'h0000_7000 + 4*i, $urandom, 2'd2, 1'b0);
      check("t6_head_addr", mem_addr, 32'h0000_3000);
      check("t6_head_data", mem_wdata, 32'hCAFE_F00D);
      check("t6_head_be", mem_be, 4'b1111);
    end
    idle(1'b1, DEPTH + 1);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1);
      end else begin
        cycle($urandom_range(0, 3) != 0, $urandom, $urandom, 2'($urandom_range(0, 3)),
              $urandom_range(0, 2) != 0);
      end
    end
    idle(1'b1, DEPTH + 2);
    check("final_count", count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
